// File: rtl/img_result_writer_if.sv
// rtl/img_result_writer_if.sv - result stream port between accelerator and result writer
interface img_result_writer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_data;
    logic [1:0]            in_data_valid;
    logic                  in_cmplt;
    logic                  in_ready;

    modport master (
        output in_data,
        output in_data_valid,
        output in_cmplt,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_data_valid,
        input  in_cmplt,
        output in_ready
    );
endinterface

// File: rtl/img_result_writer.sv
// rtl/img_result_writer.sv - buffers tagged result words and writes them to per-channel memory windows
module img_result_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] ch0_base_addr,
    input  logic [ADDR_WIDTH-1:0] ch1_base_addr,
    img_result_writer_if.slave    res,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_wr_ack,
    output logic                  ch0_done,
    output logic                  ch1_done,
    output logic                  frame_done,
    output logic                  proto_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_nxt;
    logic   start_frame;
    logic   frame_end;

    // FIFO entry layout: {last, ch, data}; ch=0 for channel 0, 1 for channel 1
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [EW-1:0] head;
    logic          head_ch;
    logic          head_last;

    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [ADDR_WIDTH-1:0] addr0_nxt, addr1_nxt;
    logic [ADDR_WIDTH-1:0] pop_addr;
    logic                  wr_ch;
    logic                  wr_last;
    logic                  wr_fire;

    logic ch0_last_seen, ch1_last_seen;
    logic accept, bad_tag, bad_after_last, bad_cmplt, push, pop;

    // Ready depends only on registered state so it never combinationally follows the input valid
    assign res.in_ready = (state == ACTIVE) && (count != FULL_CNT);

    // Input qualification, error classification and pop decision
    always_comb begin
        accept         = res.in_ready & (|res.in_data_valid);
        bad_tag        = (res.in_data_valid == 2'b11);
        bad_after_last = ((res.in_data_valid == 2'b01) & ch0_last_seen) |
                         ((res.in_data_valid == 2'b10) & ch1_last_seen);
        bad_cmplt      = res.in_ready & res.in_cmplt & (res.in_data_valid == 2'b00);
        push           = accept & ~bad_tag & ~bad_after_last;
        wr_fire        = mem_wr_en & mem_wr_ack;
        // A pop may coincide with the ack of the current write so writes can stream back-to-back
        pop            = (count != '0) & (~mem_wr_en | mem_wr_ack);
        head           = fifo_mem[rd_ptr];
        head_ch        = head[DATA_WIDTH];
        head_last      = head[DATA_WIDTH+1];
    end

    // Address counters: reload on start, advance on each acknowledged write of that channel
    always_comb begin
        addr0_nxt = addr0;
        addr1_nxt = addr1;
        if (start_frame) begin
            addr0_nxt = ch0_base_addr;
            addr1_nxt = ch1_base_addr;
        end else if (wr_fire) begin
            if (wr_ch) addr1_nxt = addr1 + 1'b1;
            else       addr0_nxt = addr0 + 1'b1;
        end
        // Use the post-ack address so a same-channel back-to-back write lands on the next word
        pop_addr = head_ch ? addr1_nxt : addr0_nxt;
    end

    // Frame FSM next-state: leave ACTIVE only when both streams ended and nothing is left to write
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (ch0_done && ch1_done && (count == '0) && !mem_wr_en) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FIFO storage; contents are meaningless until the pointers say otherwise
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {res.in_cmplt, res.in_data_valid[1], res.in_data};
    end

    // FIFO pointers and occupancy; push and pop in the same cycle leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Memory write stage: stage a popped entry, hold it until acked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            wr_ch       <= 1'b0;
            wr_last     <= 1'b0;
        end else if (pop) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= pop_addr;
            mem_wr_data <= head[DATA_WIDTH-1:0];
            wr_ch       <= head_ch;
            wr_last     <= head_last;
        end else if (mem_wr_ack) begin
            mem_wr_en   <= 1'b0;
        end
    end

    // Address counters, completion tracking, sticky flags and frame-done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr0         <= '0;
            addr1         <= '0;
            ch0_done      <= 1'b0;
            ch1_done      <= 1'b0;
            ch0_last_seen <= 1'b0;
            ch1_last_seen <= 1'b0;
            proto_err     <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            addr0      <= addr0_nxt;
            addr1      <= addr1_nxt;
            frame_done <= frame_end;
            if (start_frame) begin
                ch0_done      <= 1'b0;
                ch1_done      <= 1'b0;
                ch0_last_seen <= 1'b0;
                ch1_last_seen <= 1'b0;
                proto_err     <= 1'b0;
            end else begin
                if (wr_fire && wr_last) begin
                    if (wr_ch) ch1_done <= 1'b1;
                    else       ch0_done <= 1'b1;
                end
                if (push && res.in_cmplt) begin
                    if (res.in_data_valid[1]) ch1_last_seen <= 1'b1;
                    else                      ch0_last_seen <= 1'b1;
                end
                if ((accept && (bad_tag || bad_after_last)) || bad_cmplt) proto_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_img_result_writer.sv
// tb/tb_img_result_writer.sv - directed self-checking bench for img_result_writer
module tb_img_result_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ch0_base_addr = '0;
    logic [15:0] ch1_base_addr = '0;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ack = 1'b0;
    logic        ch0_done, ch1_done, frame_done, proto_err;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_total = 0;
    logic [15:0] wq_addr[$];
    logic [31:0] wq_data[$];

    img_result_writer_if #(.DATA_WIDTH(32)) rif ();

    img_result_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .ch0_base_addr (ch0_base_addr),
        .ch1_base_addr (ch1_base_addr),
        .res           (rif),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_ack    (mem_wr_ack),
        .ch0_done      (ch0_done),
        .ch1_done      (ch1_done),
        .frame_done    (frame_done),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    // Record completed writes and frame-done pulses away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr_en && mem_wr_ack) begin
                wq_addr.push_back(mem_wr_addr);
                wq_data.push_back(mem_wr_data);
            end
            if (frame_done) fd_total++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [15:0] b0, input logic [15:0] b1);
        ch0_base_addr = b0;
        ch1_base_addr = b1;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic push(input logic [1:0] v, input logic [31:0] d, input logic c);
        int n = 0;
        rif.in_data       = d;
        rif.in_data_valid = v;
        rif.in_cmplt      = c;
        while (!rif.in_ready && n < 200) begin
            cycles(1);
            n++;
        end
        if (n >= 200) check("push_timeout", 64'd1, 64'd0);
        cycles(1);
        rif.in_data_valid = 2'b00;
        rif.in_cmplt      = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int c = 0;
        while (wq_addr.size() < n && c < 300) begin
            cycles(1);
            c++;
        end
        if (wq_addr.size() < n) check("drain_timeout", 64'(wq_addr.size()), 64'(n));
    endtask

    task automatic exp_wr(input string tag, input int idx, input logic [15:0] a, input logic [31:0] d);
        if (idx < wq_addr.size()) begin
            check({tag, "_addr"}, 64'(wq_addr[idx]), 64'(a));
            check({tag, "_data"}, 64'(wq_data[idx]), 64'(d));
        end else begin
            check({tag, "_missing"}, 64'(wq_addr.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int base;
        int fd0;
        rif.in_data       = '0;
        rif.in_data_valid = 2'b00;
        rif.in_cmplt      = 1'b0;
        cycles(3);
        check("rst_wr_en", 64'(mem_wr_en), 64'd0);
        check("rst_ready", 64'(rif.in_ready), 64'd0);
        check("rst_flags", 64'({ch0_done, ch1_done, frame_done, proto_err}), 64'd0);
        rst_n = 1'b1;
        cycles(2);

        // 1: basic two-channel frame, ack tied high
        mem_wr_ack = 1'b1;
        base = wq_addr.size();
        fd0  = fd_total;
        do_start(16'h0100, 16'h0200);
        check("t1_ready", 64'(rif.in_ready), 64'd1);
        push(2'b01, 32'hAAAA_0001, 1'b0);
        check("t1_lat_before", 64'(mem_wr_en), 64'd0);
        push(2'b01, 32'hBBBB_0002, 1'b1);
        check("t1_lat_after", 64'({mem_wr_en, mem_wr_addr}), 64'h1_0100);
        push(2'b10, 32'hCCCC_0003, 1'b1);
        wait_writes(base + 3);
        cycles(4);
        check("t1_nwr", 64'(wq_addr.size() - base), 64'd3);
        exp_wr("t1_w0", base + 0, 16'h0100, 32'hAAAA_0001);
        exp_wr("t1_w1", base + 1, 16'h0101, 32'hBBBB_0002);
        exp_wr("t1_w2", base + 2, 16'h0200, 32'hCCCC_0003);
        check("t1_done", 64'({ch0_done, ch1_done}), 64'h3);
        check("t1_fd", 64'(fd_total - fd0), 64'd1);
        check("t1_idle_ready", 64'(rif.in_ready), 64'd0);

        // 2: back-pressure fills FIFO plus one staged write
        mem_wr_ack = 1'b0;
        base = wq_addr.size();
        do_start(16'h0300, 16'h0400);
        for (int i = 0; i < 9; i++) push(2'b01, 32'h2000_0000 + i, i == 8);
        check("t2_full", 64'(rif.in_ready), 64'd0);
        cycles(3);
        check("t2_hold", 64'({mem_wr_en, mem_wr_addr, mem_wr_data}), {15'd0, 1'b1, 16'h0300, 32'h2000_0000});
        mem_wr_ack = 1'b1;
        wait_writes(base + 9);
        for (int i = 0; i < 9; i++) exp_wr("t2_w", base + i, 16'h0300 + 16'(i), 32'h2000_0000 + i);
        push(2'b10, 32'hDDDD_0004, 1'b1);
        wait_writes(base + 10);
        exp_wr("t2_ch1", base + 9, 16'h0400, 32'hDDDD_0004);
        cycles(3);

        // 3: address wrap and cmplt without a word
        base = wq_addr.size();
        do_start(16'hFFFF, 16'h0010);
        push(2'b01, 32'h3000_0001, 1'b0);
        push(2'b01, 32'h3000_0002, 1'b1);
        check("t3_no_err", 64'(proto_err), 64'd0);
        push(2'b00, 32'h0, 1'b1);
        check("t3_cmplt_err", 64'(proto_err), 64'd1);
        push(2'b10, 32'h3000_0003, 1'b1);
        wait_writes(base + 3);
        exp_wr("t3_w0", base + 0, 16'hFFFF, 32'h3000_0001);
        exp_wr("t3_w1", base + 1, 16'h0000, 32'h3000_0002);
        exp_wr("t3_w2", base + 2, 16'h0010, 32'h3000_0003);
        cycles(3);

        // 4: illegal tag and word after last are dropped
        base = wq_addr.size();
        do_start(16'h0500, 16'h0600);
        check("t4_err_cleared", 64'(proto_err), 64'd0);
        push(2'b11, 32'hBAD0_0000, 1'b0);
        check("t4_err_tag", 64'(proto_err), 64'd1);
        push(2'b01, 32'h4000_0001, 1'b1);
        push(2'b01, 32'hBAD0_0001, 1'b0);
        push(2'b10, 32'h4000_0002, 1'b1);
        wait_writes(base + 2);
        cycles(4);
        check("t4_nwr", 64'(wq_addr.size() - base), 64'd2);
        exp_wr("t4_w0", base + 0, 16'h0500, 32'h4000_0001);
        exp_wr("t4_w1", base + 1, 16'h0600, 32'h4000_0002);
        check("t4_err_sticky", 64'(proto_err), 64'd1);

        // 5: asynchronous reset mid-frame
        mem_wr_ack = 1'b0;
        do_start(16'h0700, 16'h0780);
        check("t5_err_cleared", 64'(proto_err), 64'd0);
        for (int i = 0; i < 4; i++) push(2'b01, 32'h5000_0000 + i, 1'b0);
        check("t5_pending", 64'(mem_wr_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_out", 64'({mem_wr_en, mem_wr_addr, mem_wr_data}), 64'd0);
        check("t5_async_ready", 64'(rif.in_ready), 64'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        check("t5_idle", 64'({rif.in_ready, mem_wr_en}), 64'd0);
        mem_wr_ack = 1'b1;
        base = wq_addr.size();
        fd0  = fd_total;
        do_start(16'h0800, 16'h0900);
        push(2'b01, 32'h5100_0001, 1'b1);
        push(2'b10, 32'h5100_0002, 1'b1);
        wait_writes(base + 2);
        cycles(4);
        exp_wr("t5_w0", base + 0, 16'h0800, 32'h5100_0001);
        exp_wr("t5_w1", base + 1, 16'h0900, 32'h5100_0002);
        check("t5_fd", 64'(fd_total - fd0), 64'd1);

        // 6: start during ACTIVE is ignored
        base = wq_addr.size();
        do_start(16'h0A00, 16'h0B00);
        push(2'b01, 32'h6000_0001, 1'b0);
        push(2'b01, 32'h6000_0002, 1'b1);
        wait_writes(base + 2);
        cycles(1);
        check("t6_ch0_done", 64'(ch0_done), 64'd1);
        do_start(16'h0C00, 16'h0D00);
        check("t6_done_kept", 64'({ch0_done, ch1_done}), 64'h2);
        push(2'b10, 32'h6000_0003, 1'b1);
        wait_writes(base + 3);
        exp_wr("t6_w0", base + 0, 16'h0A00, 32'h6000_0001);
        exp_wr("t6_w1", base + 1, 16'h0A01, 32'h6000_0002);
        exp_wr("t6_w2", base + 2, 16'h0B00, 32'h6000_0003);
        cycles(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
